// File: rtl/riscv_pkg.sv
// RISC-V encodings shared by the writeback stage: opcodes, load funct3 values,
// exception causes and the canonical NOP.
package riscv_pkg;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LD  = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] LWU = 3'b110;

   localparam int unsigned CAUSE_LOAD_ACCESS_FAULT = 5;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   // Opcodes whose result is written back to rd
   function automatic logic writes_rd(input logic [6:0] opc);
      case (opc)
         OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM32, OPC_OP,
         OPC_LUI, OPC_OP32, OPC_JALR, OPC_JAL, OPC_SYSTEM: writes_rd = 1'b1;
         default:                                          writes_rd = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/riscv_state_pkg.sv
// State encoding for the writeback load-tracking FSM.
package riscv_state_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } wb_state_t;

endpackage

// File: rtl/riscv_wb_align.sv
// Load data alignment: shifts the naturally aligned response word down to the
// accessed byte lane and sign/zero-extends according to funct3.
module riscv_wb_align
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32
)(
   input  logic [2:0]                  funct3,
   input  logic [$clog2(XLEN/8)-1:0]   addr,
   input  logic [XLEN-1:0]             q,
   output logic [XLEN-1:0]             data_c
);

   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] mask;
   logic            msb;
   logic            sext;

   always_comb begin
      shifted = q >> {addr, 3'b000};
      mask    = '1;
      msb     = shifted[XLEN-1];
      case (funct3)
         LB, LBU: begin
            mask = XLEN'(8'hFF);
            msb  = shifted[7];
         end
         LH, LHU: begin
            mask = XLEN'(16'hFFFF);
            msb  = shifted[15];
         end
         LW, LWU: begin
            mask = XLEN'(32'hFFFF_FFFF);
            msb  = shifted[31];
         end
         default: ;
      endcase
      sext   = (funct3 inside {LB, LH, LW, LD}) && msb;
      data_c = (shifted & mask) | (sext ? ~mask : '0);
   end

endmodule

// File: rtl/riscv_wb_load.sv
// Writeback stage load handling: aligns load responses, selects rd write data and
// stalls MEM/EX until a pending load returns. Define RV12_DMEM_ERR_EN to turn
// dmem bus errors into load access faults.
module riscv_wb_load
   import riscv_pkg::*;
   import riscv_state_pkg::*;
#(
   parameter int unsigned     XLEN            = 32,
   parameter int unsigned     ILEN            = 32,
   parameter logic [XLEN-1:0] PC_INIT         = 'h200,
   parameter int unsigned     EXCEPTION_SIZE  = 12,
   parameter int unsigned     MAX_OUTSTANDING = 2
)(
   input  logic                      rstn,
   input  logic                      clk,
   input  logic [XLEN-1:0]           mem_pc,
   input  logic [ILEN-1:0]           mem_instr,
   input  logic                      mem_bubble,
   input  logic [EXCEPTION_SIZE-1:0] mem_exception,
   input  logic [XLEN-1:0]           mem_r,
   input  logic [XLEN-1:0]           mem_memadr,
   input  logic                      dmem_req,
   input  logic                      dmem_ack,
   input  logic [XLEN-1:0]           dmem_q,
   input  logic                      dmem_err,
   output logic                      wb_stall,
   output logic [XLEN-1:0]           wb_pc,
   output logic [ILEN-1:0]           wb_instr,
   output logic                      wb_bubble,
   output logic [EXCEPTION_SIZE-1:0] wb_exception,
   output logic [XLEN-1:0]           wb_r,
   output logic                      wb_we,
   output logic [4:0]                wb_dst,
   output logic [XLEN-1:0]           wb_badaddr
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned AW    = $clog2(XLEN / 8);

   wb_state_t        state, state_nxt;
   logic [CNT_W-1:0] outstanding, outstanding_nxt;
   logic [CNT_W-1:0] discard, discard_nxt;
   logic [6:0]       opcode;
   logic [4:0]       rd;
   logic             mem_ok;
   logic             is_load;
   logic             flush;
   logic [XLEN-1:0]  load_data;
   logic             unused_bits;

   assign opcode   = mem_instr[6:0];
   assign rd       = mem_instr[11:7];
   assign mem_ok   = !mem_bubble && ~|mem_exception;
   assign is_load  = mem_ok && (opcode == OPC_LOAD);
   assign flush    = |wb_exception;
   assign wb_stall = is_load && (!dmem_ack || (discard != '0));

`ifdef RV12_DMEM_ERR_EN
   assign unused_bits = ^mem_instr[ILEN-1:15];
`else
   assign unused_bits = ^{mem_instr[ILEN-1:15], dmem_err};
`endif

   riscv_wb_align #(.XLEN(XLEN)) u_align (
      .funct3 (mem_instr[14:12]),
      .addr   (mem_memadr[AW-1:0]),
      .q      (dmem_q),
      .data_c (load_data)
   );

   // Requests in flight; a simultaneous req and ack cancel out
   always_comb begin
      outstanding_nxt = outstanding;
      if (dmem_req && !dmem_ack)      outstanding_nxt = outstanding + CNT_W'(1);
      else if (dmem_ack && !dmem_req) outstanding_nxt = outstanding - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) outstanding <= '0;
      else       outstanding <= outstanding_nxt;
   end

   // FSM state register (discard count travels with it)
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_RUN;
         discard <= '0;
      end else begin
         state   <= state_nxt;
         discard <= discard_nxt;
      end
   end

   // FSM next state; a flush wins over normal progress
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = (outstanding_nxt != '0) ? ST_DRAIN : ST_RUN;
      end else begin
         case (state)
            ST_RUN:   if (is_load && !dmem_ack && (discard == '0)) state_nxt = ST_WAIT;
            ST_WAIT:  if (dmem_ack) state_nxt = ST_RUN;
            ST_DRAIN: if ((discard == '0) || (dmem_ack && (discard == CNT_W'(1))))
                         state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
         endcase
      end
   end

   // FSM outputs: responses belonging to squashed loads are counted off here
   always_comb begin
      discard_nxt = discard;
      if (flush)
         discard_nxt = outstanding_nxt;
      else if ((state == ST_DRAIN) && dmem_ack && (discard != '0))
         discard_nxt = discard - CNT_W'(1);
   end

   // Writeback register; stall and flush both insert a bubble
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wb_pc        <= PC_INIT;
         wb_instr     <= ILEN'(INSTR_NOP);
         wb_bubble    <= 1'b1;
         wb_exception <= '0;
         wb_r         <= '0;
         wb_we        <= 1'b0;
         wb_dst       <= '0;
         wb_badaddr   <= '0;
      end else if (flush || wb_stall) begin
         wb_bubble    <= 1'b1;
         wb_we        <= 1'b0;
         wb_exception <= '0;
      end else begin
         wb_pc        <= mem_pc;
         wb_instr     <= mem_instr;
         wb_bubble    <= mem_bubble;
         wb_dst       <= rd;
         wb_r         <= is_load ? load_data : mem_r;
         wb_we        <= mem_ok && writes_rd(opcode) && (rd != '0);
         wb_exception <= mem_exception;
         wb_badaddr   <= mem_memadr;
`ifdef RV12_DMEM_ERR_EN
         if (is_load && dmem_err) begin
            wb_exception[CAUSE_LOAD_ACCESS_FAULT] <= 1'b1;
            wb_we                                 <= 1'b0;
         end
`endif
      end
   end

   a_req_overflow: assert property (@(posedge clk) disable iff (!rstn)
      !(dmem_req && !dmem_ack && (outstanding == CNT_W'(MAX_OUTSTANDING))));

   a_ack_underflow: assert property (@(posedge clk) disable iff (!rstn)
      !(dmem_ack && !dmem_req && (outstanding == '0)));

endmodule

// File: tb/tb_riscv_wb_load.sv
// Directed bench for riscv_wb_load: ALU writeback, load alignment, stalls,
// flush draining, bus errors and reset during a pending load.
module tb_riscv_wb_load;
   import riscv_pkg::*;
   import riscv_state_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] mem_pc, mem_instr, mem_r, mem_memadr, dmem_q;
   logic        mem_bubble, dmem_req, dmem_ack, dmem_err;
   logic [11:0] mem_exception;
   logic        wb_stall, wb_bubble, wb_we;
   logic [31:0] wb_pc, wb_instr, wb_r, wb_badaddr;
   logic [11:0] wb_exception;
   logic [4:0]  wb_dst;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   riscv_wb_load dut (
      .rstn          (rstn),
      .clk           (clk),
      .mem_pc        (mem_pc),
      .mem_instr     (mem_instr),
      .mem_bubble    (mem_bubble),
      .mem_exception (mem_exception),
      .mem_r         (mem_r),
      .mem_memadr    (mem_memadr),
      .dmem_req      (dmem_req),
      .dmem_ack      (dmem_ack),
      .dmem_q        (dmem_q),
      .dmem_err      (dmem_err),
      .wb_stall      (wb_stall),
      .wb_pc         (wb_pc),
      .wb_instr      (wb_instr),
      .wb_bubble     (wb_bubble),
      .wb_exception  (wb_exception),
      .wb_r          (wb_r),
      .wb_we         (wb_we),
      .wb_dst        (wb_dst),
      .wb_badaddr    (wb_badaddr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      mem_pc        = 32'h0;
      mem_instr     = 32'h0000_0013;
      mem_bubble    = 1'b1;
      mem_exception = 12'h0;
      mem_r         = 32'h0;
      mem_memadr    = 32'h0;
      dmem_req      = 1'b0;
      dmem_ack      = 1'b0;
      dmem_q        = 32'h0;
      dmem_err      = 1'b0;
   endtask

   task automatic set_mem(input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] r, input logic [31:0] adr);
      mem_pc     = pc;
      mem_instr  = ins;
      mem_bubble = 1'b0;
      mem_r      = r;
      mem_memadr = adr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, " wb_pc"},        64'(wb_pc),        64'h200);
      chk({tag, " wb_instr"},     64'(wb_instr),     64'h13);
      chk({tag, " wb_bubble"},    64'(wb_bubble),    64'h1);
      chk({tag, " wb_exception"}, 64'(wb_exception), 64'h0);
      chk({tag, " wb_r"},         64'(wb_r),         64'h0);
      chk({tag, " wb_we"},        64'(wb_we),        64'h0);
      chk({tag, " wb_dst"},       64'(wb_dst),       64'h0);
      chk({tag, " wb_badaddr"},   64'(wb_badaddr),   64'h0);
   endtask

   initial begin
      idle();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_values("rst");
      chk("rst stall", 64'(wb_stall), 64'h0);
      @(negedge clk);
      rstn = 1'b1;
      tick();

      // ADD x5
      set_mem(32'h300, 32'h0000_02B3, 32'h1234, 32'h0);
      #1 chk("add stall", 64'(wb_stall), 64'h0);
      tick();
      chk("add wb_r",   64'(wb_r),      64'h1234);
      chk("add wb_we",  64'(wb_we),     64'h1);
      chk("add wb_dst", 64'(wb_dst),    64'h5);
      chk("add bubble", 64'(wb_bubble), 64'h0);
      chk("add wb_pc",  64'(wb_pc),     64'h300);

      // ADD x0 never writes
      set_mem(32'h304, 32'h0000_0033, 32'h99, 32'h0);
      tick();
      chk("x0 wb_we", 64'(wb_we), 64'h0);

      // LB x6, addr 0x103, same-cycle ack
      set_mem(32'h308, 32'h0000_0303, 32'hAAAA, 32'h103);
      dmem_req = 1'b1; dmem_ack = 1'b1; dmem_q = 32'h80FF_FFFF;
      #1 chk("lb stall", 64'(wb_stall), 64'h0);
      tick();
      chk("lb wb_r",   64'(wb_r),   64'hFFFF_FF80);
      chk("lb wb_we",  64'(wb_we),  64'h1);
      chk("lb wb_dst", 64'(wb_dst), 64'h6);

      // LBU x10, addr 0x101
      set_mem(32'h30C, 32'h0000_4503, 32'h0, 32'h101);
      dmem_q = 32'h0000_A500;
      tick();
      chk("lbu wb_r", 64'(wb_r), 64'hA5);

      // LH x11, addr 0x100
      set_mem(32'h310, 32'h0000_1583, 32'h0, 32'h100);
      dmem_q = 32'h0000_8001;
      tick();
      chk("lh wb_r", 64'(wb_r), 64'hFFFF_8001);
      idle();

      // LHU x7, addr 0x102, response three cycles late
      set_mem(32'h314, 32'h0000_5383, 32'h0, 32'h102);
      dmem_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1 chk("lhu stall", 64'(wb_stall), 64'h1);
         tick();
         dmem_req = 1'b0;
         chk("lhu bubble", 64'(wb_bubble), 64'h1);
         chk("lhu wb_we",  64'(wb_we),     64'h0);
         chk("lhu state",  64'(dut.state), 64'(ST_WAIT));
      end
      dmem_ack = 1'b1; dmem_q = 32'hBEEF_0000;
      #1 chk("lhu ack stall", 64'(wb_stall), 64'h0);
      tick();
      chk("lhu wb_r",   64'(wb_r),      64'h0000_BEEF);
      chk("lhu wb_we",  64'(wb_we),     64'h1);
      chk("lhu wb_dst", 64'(wb_dst),    64'h7);
      chk("lhu bubble", 64'(wb_bubble), 64'h0);
      chk("lhu run",    64'(dut.state), 64'(ST_RUN));
      idle();

      // Two requests in flight, then an excepting instruction flushes them
      dmem_req = 1'b1;
      tick();
      set_mem(32'h320, 32'h0000_02B3, 32'h5555, 32'h0);
      mem_exception = 12'h004;
      dmem_req = 1'b1;
      tick();
      chk("exc wb_exception", 64'(wb_exception), 64'h004);
      chk("exc wb_we",        64'(wb_we),        64'h0);
      idle();
      tick();
      chk("flush wb_exception", 64'(wb_exception), 64'h0);
      chk("flush bubble",       64'(wb_bubble),    64'h1);
      chk("flush state",        64'(dut.state),    64'(ST_DRAIN));
      set_mem(32'h330, 32'h0000_2483, 32'h0, 32'h200);
      dmem_ack = 1'b1; dmem_q = 32'hDEAD_BEEF;
      #1 chk("drain1 stall", 64'(wb_stall), 64'h1);
      tick();
      chk("drain1 wb_we",  64'(wb_we),     64'h0);
      chk("drain1 bubble", 64'(wb_bubble), 64'h1);
      #1 chk("drain2 stall", 64'(wb_stall), 64'h1);
      tick();
      chk("drain2 wb_we", 64'(wb_we),     64'h0);
      chk("drain2 state", 64'(dut.state), 64'(ST_RUN));
      dmem_req = 1'b1; dmem_q = 32'h1122_3344;
      #1 chk("post-drain stall", 64'(wb_stall), 64'h0);
      tick();
      chk("post-drain wb_r",   64'(wb_r),   64'h1122_3344);
      chk("post-drain wb_we",  64'(wb_we),  64'h1);
      chk("post-drain wb_dst", 64'(wb_dst), 64'h9);
      idle();

      // LW x8 with bus error on the response
      set_mem(32'h340, 32'h0000_2403, 32'h0, 32'h2000);
      dmem_req = 1'b1; dmem_ack = 1'b1; dmem_err = 1'b1; dmem_q = 32'h1234_5678;
      #1 chk("err stall", 64'(wb_stall), 64'h0);
      tick();
`ifdef RV12_DMEM_ERR_EN
      chk("err wb_exception", 64'(wb_exception), 64'h020);
      chk("err wb_we",        64'(wb_we),        64'h0);
      chk("err wb_badaddr",   64'(wb_badaddr),   64'h2000);
`else
      chk("err wb_exception", 64'(wb_exception), 64'h0);
      chk("err wb_we",        64'(wb_we),        64'h1);
      chk("err wb_r",         64'(wb_r),         64'h1234_5678);
`endif
      idle();
      tick();
      chk("err next wb_exception", 64'(wb_exception), 64'h0);
      chk("err next state",        64'(dut.state),    64'(ST_RUN));

      // Reset while waiting on a load response
      set_mem(32'h350, 32'h0000_5383, 32'h0, 32'h102);
      dmem_req = 1'b1;
      #1 chk("wait stall", 64'(wb_stall), 64'h1);
      tick();
      chk("wait state", 64'(dut.state), 64'(ST_WAIT));
      idle();
      rstn = 1'b0;
      #1;
      chk_reset_values("midrst");
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("midrst stall", 64'(wb_stall),  64'h0);
      chk("midrst state", 64'(dut.state), 64'(ST_RUN));
      tick();
      chk("midrst bubble", 64'(wb_bubble), 64'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
